id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the RV32I pipeline. It sits directly upstream of the ALU and drives val1/val2/aluop.
- Registers decoded operands with a valid/ready handshake, applies flush, and selects operand sources (rs/pc/imm).
- Resolves RAW hazards by forwarding from MEM/WB, or by stalling when forwarding is compiled out.
- Latency is one cycle from ID accept to operands valid at the ALU.

---
 rtl/id_ex_stage_pkg.sv | 37 +++
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage_fwd_mux.sv | 41 ++++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared constants for the ID/EX stage.
// Holds the ALU opcode set, the operand source selects and the datapath widths.
// Optional feature macro used by the stage: ID_EX_FWD_EN (MEM/WB forwarding).
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'h0,
        ALUOP_SUB  = 4'h1,
        ALUOP_SLL  = 4'h2,
        ALUOP_SLT  = 4'h3,
        ALUOP_SLTU = 4'h4,
        ALUOP_XOR  = 4'h5,
        ALUOP_SRL  = 4'h6,
        ALUOP_SRA  = 4'h7,
        ALUOP_OR   = 4'h8,
        ALUOP_AND  = 4'h9,
        ALUOP_LUI  = 4'hA
    } aluop_e;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    // True when a writer targets the given source register; x0 never matches.
    function automatic logic rs_match(
        input logic              regwrite,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return regwrite && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side, EX-side and MEM/WB bypass signals of the ID/EX stage.
// slave is the stage itself, master is whatever surrounds it.
// Related feature macro: ID_EX_FWD_EN (no signal differences between builds).
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid_i;
    logic              id_ready_o;
    logic [XLEN-1:0]   id_pc_i;
    logic [XLEN-1:0]   id_rs1_val_i;
    logic [XLEN-1:0]   id_rs2_val_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [REG_AW-1:0] id_rs1_addr_i;
    logic [REG_AW-1:0] id_rs2_addr_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic [3:0]        id_aluop_i;
    logic              id_src1_sel_i;
    logic              id_src2_sel_i;
    logic              id_regwrite_i;
    logic              flush_i;
    logic              ex_ready_i;
    logic              mem_regwrite_i;
    logic [REG_AW-1:0] mem_rd_addr_i;
    logic [XLEN-1:0]   mem_result_i;
    logic              wb_regwrite_i;
    logic [REG_AW-1:0] wb_rd_addr_i;
    logic [XLEN-1:0]   wb_result_i;
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_val1_o;
    logic [XLEN-1:0]   ex_val2_o;
    logic [3:0]        ex_aluop_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [REG_AW-1:0] ex_rd_addr_o;
    logic              ex_regwrite_o;
    logic [XLEN-1:0]   ex_pc_o;

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_val_i, id_rs2_val_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_aluop_i,
               id_src1_sel_i, id_src2_sel_i, id_regwrite_i, flush_i, ex_ready_i,
               mem_regwrite_i, mem_rd_addr_i, mem_result_i,
               wb_regwrite_i, wb_rd_addr_i, wb_result_i,
        output id_ready_o, ex_valid_o, ex_val1_o, ex_val2_o, ex_aluop_o,
               ex_rs2_data_o, ex_rd_addr_o, ex_regwrite_o, ex_pc_o
    );

    modport master (
        output id_valid_i, id_pc_i, id_rs1_val_i, id_rs2_val_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_aluop_i,
               id_src1_sel_i, id_src2_sel_i, id_regwrite_i, flush_i, ex_ready_i,
               mem_regwrite_i, mem_rd_addr_i, mem_result_i,
               wb_regwrite_i, wb_rd_addr_i, wb_result_i,
        input  id_ready_o, ex_valid_o, ex_val1_o, ex_val2_o, ex_aluop_o,
               ex_rs2_data_o, ex_rd_addr_o, ex_regwrite_o, ex_pc_o
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: bypass mux for one EX source operand.
// ID_EX_FWD_EN defined: MEM match beats WB match beats the stored value.
// ID_EX_FWD_EN undefined: the stored value passes straight through.
import id_ex_stage_pkg::*;

module id_ex_stage_fwd_mux #(
    parameter int XLEN   = id_ex_stage_pkg::XLEN,
    parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   stored_val,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   fwd_val
);

`ifdef ID_EX_FWD_EN
    // Youngest producer wins: MEM overrides WB, both override the stored value.
    always_comb begin
        fwd_val = stored_val;
        if (rs_match(wb_regwrite, wb_rd_addr, rs_addr)) begin
            fwd_val = wb_result;
        end
        if (rs_match(mem_regwrite, mem_rd_addr, rs_addr)) begin
            fwd_val = mem_result;
        end
    end
`else
    // Hazards are stalled upstream, so the stored value is always current.
    assign fwd_val = stored_val;

    logic unused_bypass;
    assign unused_bypass = ^{rs_addr, mem_regwrite, mem_rd_addr, mem_result,
                             wb_regwrite, wb_rd_addr, wb_result};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the RV32I core.
// Registers decoded operands behind a valid/ready handshake, applies flush,
// bypasses MEM/WB results into the stored operands and selects ALU sources.
// Feature macro ID_EX_FWD_EN: defined -> forwarding, undefined -> hazard stall.
import id_ex_stage_pkg::*;

module id_ex_stage #(
    parameter int XLEN   = id_ex_stage_pkg::XLEN,
    parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

    logic              valid_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   rs1_val_reg;
    logic [XLEN-1:0]   rs2_val_reg;
    logic [XLEN-1:0]   imm_reg;
    logic [REG_AW-1:0] rs1_addr_reg;
    logic [REG_AW-1:0] rs2_addr_reg;
    logic [REG_AW-1:0] rd_addr_reg;
    logic [3:0]        aluop_reg;
    logic              src1_sel_reg;
    logic              src2_sel_reg;
    logic              regwrite_reg;

    logic [REG_AW-1:0] src_addr [2];
    logic [XLEN-1:0]   src_val  [2];
    logic [XLEN-1:0]   src_fwd  [2];
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    logic              ex_live_write;
    logic              hazard;
    logic              ready;
    logic              accept;

    assign src_addr[0] = rs1_addr_reg;
    assign src_addr[1] = rs2_addr_reg;
    assign src_val[0]  = rs1_val_reg;
    assign src_val[1]  = rs2_val_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            id_ex_stage_fwd_mux #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW)
            ) u_fwd_mux (
                .rs_addr      (src_addr[gi]),
                .stored_val   (src_val[gi]),
                .mem_regwrite (bus.mem_regwrite_i),
                .mem_rd_addr  (bus.mem_rd_addr_i),
                .mem_result   (bus.mem_result_i),
                .wb_regwrite  (bus.wb_regwrite_i),
                .wb_rd_addr   (bus.wb_rd_addr_i),
                .wb_result    (bus.wb_result_i),
                .fwd_val      (src_fwd[gi])
            );
        end
    endgenerate

    assign fwd_rs1 = src_fwd[0];
    assign fwd_rs2 = src_fwd[1];

    // A live EX instruction that will write rd; regwrite never leaks when idle.
    assign ex_live_write = valid_reg & regwrite_reg;

`ifdef ID_EX_FWD_EN
    assign hazard = 1'b0;
`else
    // Without bypassing, any in-flight writer of an ID source blocks the ID
    // instruction. WB is safe because the register file writes before reading.
    always_comb begin
        hazard = bus.id_valid_i &
                 (rs_match(ex_live_write, rd_addr_reg, bus.id_rs1_addr_i) |
                  rs_match(ex_live_write, rd_addr_reg, bus.id_rs2_addr_i) |
                  rs_match(bus.mem_regwrite_i, bus.mem_rd_addr_i, bus.id_rs1_addr_i) |
                  rs_match(bus.mem_regwrite_i, bus.mem_rd_addr_i, bus.id_rs2_addr_i));
    end
`endif

    // Flush does not gate ready; it only kills whatever lands in the register.
    assign ready          = (~valid_reg | bus.ex_ready_i) & ~hazard;
    assign accept         = bus.id_valid_i & ready;
    assign bus.id_ready_o = ready;

    // Stage register: reset, then flush, accept, drain, and hold with refresh.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            rs1_val_reg  <= '0;
            rs2_val_reg  <= '0;
            imm_reg      <= '0;
            rs1_addr_reg <= '0;
            rs2_addr_reg <= '0;
            rd_addr_reg  <= '0;
            aluop_reg    <= '0;
            src1_sel_reg <= 1'b0;
            src2_sel_reg <= 1'b0;
            regwrite_reg <= 1'b0;
        end else if (bus.flush_i) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
        end else if (accept) begin
            valid_reg    <= 1'b1;
            pc_reg       <= bus.id_pc_i;
            rs1_val_reg  <= bus.id_rs1_val_i;
            rs2_val_reg  <= bus.id_rs2_val_i;
            imm_reg      <= bus.id_imm_i;
            rs1_addr_reg <= bus.id_rs1_addr_i;
            rs2_addr_reg <= bus.id_rs2_addr_i;
            rd_addr_reg  <= bus.id_rd_addr_i;
            aluop_reg    <= bus.id_aluop_i;
            src1_sel_reg <= bus.id_src1_sel_i;
            src2_sel_reg <= bus.id_src2_sel_i;
            regwrite_reg <= bus.id_regwrite_i;
        end else if (valid_reg & bus.ex_ready_i) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
        end else if (valid_reg) begin
            // Capture producers retiring while stalled so their values survive.
            rs1_val_reg  <= fwd_rs1;
            rs2_val_reg  <= fwd_rs2;
        end
    end

    assign bus.ex_valid_o    = valid_reg;
    assign bus.ex_val1_o     = (src1_sel_reg == SRC1_PC)  ? pc_reg  : fwd_rs1;
    assign bus.ex_val2_o     = (src2_sel_reg == SRC2_IMM) ? imm_reg : fwd_rs2;
    assign bus.ex_aluop_o    = aluop_reg;
    assign bus.ex_rs2_data_o = fwd_rs2;
    assign bus.ex_rd_addr_o  = rd_addr_reg;
    assign bus.ex_regwrite_o = ex_live_write;
    assign bus.ex_pc_o       = pc_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// A transaction-level model of the stage is checked against the DUT every cycle,
// with directed scenarios pinning literal values. Honours ID_EX_FWD_EN.
import id_ex_stage_pkg::*;

module tb_id_ex_stage;

    logic clk_i;
    logic rst_i;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  aluop;
        logic        s1;
        logic        s2;
        logic        rw;
    } entry_t;

    entry_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a source register must have: youngest in-flight writer, else stored.
    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] stored);
`ifdef ID_EX_FWD_EN
        if (rs != 0 && bus.mem_regwrite_i && bus.mem_rd_addr_i == rs) return bus.mem_result_i;
        if (rs != 0 && bus.wb_regwrite_i && bus.wb_rd_addr_i == rs) return bus.wb_result_i;
`endif
        return stored;
    endfunction

`ifndef ID_EX_FWD_EN
    function automatic logic model_conflict(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        return (m.valid && m.rw && m.rd == rs) ||
               (bus.mem_regwrite_i && bus.mem_rd_addr_i == rs);
    endfunction
`endif

    function automatic logic model_ready();
        logic ok;
        ok = !m.valid || bus.ex_ready_i;
`ifndef ID_EX_FWD_EN
        if (bus.id_valid_i && (model_conflict(bus.id_rs1_addr_i) || model_conflict(bus.id_rs2_addr_i)))
            ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic compare_outputs();
        if (rst_i) begin
            chk("rst_valid",    32'(bus.ex_valid_o),    32'd0);
            chk("rst_val1",     bus.ex_val1_o,          32'd0);
            chk("rst_val2",     bus.ex_val2_o,          32'd0);
            chk("rst_aluop",    32'(bus.ex_aluop_o),    32'd0);
            chk("rst_rs2data",  bus.ex_rs2_data_o,      32'd0);
            chk("rst_rd",       32'(bus.ex_rd_addr_o),  32'd0);
            chk("rst_regwrite", 32'(bus.ex_regwrite_o), 32'd0);
            chk("rst_pc",       bus.ex_pc_o,            32'd0);
        end else begin
            chk("id_ready",  32'(bus.id_ready_o),    32'(model_ready()));
            chk("ex_valid",  32'(bus.ex_valid_o),    32'(m.valid));
            chk("regwrite",  32'(bus.ex_regwrite_o), 32'(m.valid && m.rw));
            if (m.valid) begin
                chk("val1",    bus.ex_val1_o,         m.s1 ? m.pc  : model_fwd(m.rs1, m.rs1v));
                chk("val2",    bus.ex_val2_o,         m.s2 ? m.imm : model_fwd(m.rs2, m.rs2v));
                chk("aluop",   32'(bus.ex_aluop_o),   32'(m.aluop));
                chk("rs2data", bus.ex_rs2_data_o,     model_fwd(m.rs2, m.rs2v));
                chk("rd",      32'(bus.ex_rd_addr_o), 32'(m.rd));
                chk("pc",      bus.ex_pc_o,           m.pc);
            end
        end
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic update_model();
        if (rst_i) begin
            m = '{default: '0};
        end else if (bus.flush_i) begin
            m.valid = 1'b0;
            m.rw    = 1'b0;
        end else if (bus.id_valid_i && model_ready()) begin
            m.valid = 1'b1;
            m.pc    = bus.id_pc_i;
            m.rs1v  = bus.id_rs1_val_i;
            m.rs2v  = bus.id_rs2_val_i;
            m.imm   = bus.id_imm_i;
            m.rs1   = bus.id_rs1_addr_i;
            m.rs2   = bus.id_rs2_addr_i;
            m.rd    = bus.id_rd_addr_i;
            m.aluop = bus.id_aluop_i;
            m.s1    = bus.id_src1_sel_i;
            m.s2    = bus.id_src2_sel_i;
            m.rw    = bus.id_regwrite_i;
            $display("accept pc=%h rs1=x%0d rs2=x%0d rd=x%0d op=%0d", m.pc, m.rs1, m.rs2, m.rd, m.aluop);
        end else if (m.valid && bus.ex_ready_i) begin
            m.valid = 1'b0;
        end else if (m.valid) begin
            m.rs1v = model_fwd(m.rs1, m.rs1v);
            m.rs2v = model_fwd(m.rs2, m.rs2v);
        end
    endtask

    task automatic step();
        #1 compare_outputs();
        @(posedge clk_i);
        update_model();
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.id_valid_i     = 1'b0;
        bus.id_pc_i        = '0;
        bus.id_rs1_val_i   = '0;
        bus.id_rs2_val_i   = '0;
        bus.id_imm_i       = '0;
        bus.id_rs1_addr_i  = '0;
        bus.id_rs2_addr_i  = '0;
        bus.id_rd_addr_i   = '0;
        bus.id_aluop_i     = '0;
        bus.id_src1_sel_i  = SRC1_RS1;
        bus.id_src2_sel_i  = SRC2_RS2;
        bus.id_regwrite_i  = 1'b0;
        bus.flush_i        = 1'b0;
        bus.ex_ready_i     = 1'b1;
        bus.mem_regwrite_i = 1'b0;
        bus.mem_rd_addr_i  = '0;
        bus.mem_result_i   = '0;
        bus.wb_regwrite_i  = 1'b0;
        bus.wb_rd_addr_i   = '0;
        bus.wb_result_i    = '0;
    endtask

    task automatic drive_random();
        bus.id_valid_i     = ($urandom_range(0, 9) < 7);
        bus.id_pc_i        = $urandom;
        bus.id_rs1_val_i   = $urandom;
        bus.id_rs2_val_i   = $urandom;
        bus.id_imm_i       = $urandom;
        bus.id_rs1_addr_i  = 5'($urandom_range(0, 7));
        bus.id_rs2_addr_i  = 5'($urandom_range(0, 7));
        bus.id_rd_addr_i   = 5'($urandom_range(0, 7));
        bus.id_aluop_i     = 4'($urandom_range(0, 10));
        bus.id_src1_sel_i  = 1'($urandom_range(0, 1));
        bus.id_src2_sel_i  = 1'($urandom_range(0, 1));
        bus.id_regwrite_i  = 1'($urandom_range(0, 1));
        bus.flush_i        = ($urandom_range(0, 19) == 0);
        bus.ex_ready_i     = ($urandom_range(0, 9) < 6);
        bus.mem_regwrite_i = 1'($urandom_range(0, 1));
        bus.mem_rd_addr_i  = 5'($urandom_range(0, 7));
        bus.mem_result_i   = $urandom;
        bus.wb_regwrite_i  = 1'($urandom_range(0, 1));
        bus.wb_rd_addr_i   = 5'($urandom_range(0, 7));
        bus.wb_result_i    = $urandom;
        rst_i              = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        m = '{default: '0};
        rst_i = 1'b1;
        idle();
        repeat (2) @(negedge clk_i);
        step();
        rst_i = 1'b0;

        // ADDI x5, x1, 7 with x1 = 10
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_pc_i       = 32'h100;
        bus.id_rs1_addr_i = 5'd1;
        bus.id_rs1_val_i  = 32'd10;
        bus.id_imm_i      = 32'd7;
        bus.id_rd_addr_i  = 5'd5;
        bus.id_aluop_i    = ALUOP_ADD;
        bus.id_src2_sel_i = SRC2_IMM;
        bus.id_regwrite_i = 1'b1;
        step();
        chk("addi_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("addi_val1",  bus.ex_val1_o,       32'd10);
        chk("addi_val2",  bus.ex_val2_o,       32'd7);
        chk("addi_aluop", 32'(bus.ex_aluop_o), 32'(ALUOP_ADD));
        idle();
        step();

        // Asynchronous reset while an instruction is held and ID is offering more
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_pc_i       = 32'h200;
        bus.id_rd_addr_i  = 5'd7;
        bus.id_regwrite_i = 1'b1;
        bus.id_imm_i      = 32'h1234;
        bus.id_src2_sel_i = SRC2_IMM;
        step();
        bus.ex_ready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid",    32'(bus.ex_valid_o),    32'd0);
        chk("arst_regwrite", 32'(bus.ex_regwrite_o), 32'd0);
        chk("arst_val2",     bus.ex_val2_o,          32'd0);
        chk("arst_pc",       bus.ex_pc_o,            32'd0);
        step();
        rst_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        #1 chk("post_rst_idle", 32'(bus.ex_valid_o), 32'd0);
        step();
        chk("post_rst_accept", 32'(bus.ex_valid_o), 32'd1);
        chk("post_rst_pc",     bus.ex_pc_o,         32'h200);
        idle();
        step();

        // Flush in the same cycle as an accept drops the instruction
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_pc_i       = 32'h240;
        bus.id_rd_addr_i  = 5'd9;
        bus.id_regwrite_i = 1'b1;
        bus.flush_i       = 1'b1;
        step();
        chk("flush_valid",    32'(bus.ex_valid_o),    32'd0);
        chk("flush_regwrite", 32'(bus.ex_regwrite_o), 32'd0);
        idle();
        step();

`ifdef ID_EX_FWD_EN
        // MEM beats WB on the same source register
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_rs1_addr_i = 5'd3;
        bus.id_rs1_val_i  = 32'h11;
        step();
        bus.id_valid_i     = 1'b0;
        bus.ex_ready_i     = 1'b0;
        bus.mem_regwrite_i = 1'b1;
        bus.mem_rd_addr_i  = 5'd3;
        bus.mem_result_i   = 32'hAA;
        bus.wb_regwrite_i  = 1'b1;
        bus.wb_rd_addr_i   = 5'd3;
        bus.wb_result_i    = 32'hBB;
        #1 chk("fwd_mem_prio", bus.ex_val1_o, 32'hAA);
        bus.mem_regwrite_i = 1'b0;
        #1 chk("fwd_wb", bus.ex_val1_o, 32'hBB);
        step();
        idle();
        step();

        // x0 is never forwarded
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_rs1_addr_i = 5'd0;
        bus.id_rs1_val_i  = 32'h22;
        step();
        bus.id_valid_i     = 1'b0;
        bus.ex_ready_i     = 1'b0;
        bus.mem_regwrite_i = 1'b1;
        bus.mem_rd_addr_i  = 5'd0;
        bus.mem_result_i   = 32'hAA;
        #1 chk("fwd_x0", bus.ex_val1_o, 32'h22);
        step();
        idle();
        step();

        // Stall refresh: WB writes x4 only in the first stalled cycle
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_rs2_addr_i = 5'd4;
        bus.id_rs2_val_i  = 32'h11;
        step();
        bus.id_pc_i       = 32'h400;
        bus.ex_ready_i    = 1'b0;
        bus.wb_regwrite_i = 1'b1;
        bus.wb_rd_addr_i  = 5'd4;
        bus.wb_result_i   = 32'h55;
        #1 chk("stall_ready_c1", 32'(bus.id_ready_o), 32'd0);
        step();
        bus.wb_regwrite_i = 1'b0;
        #1 chk("stall_rs2_c2",   bus.ex_rs2_data_o,   32'h55);
        chk("stall_ready_c2",    32'(bus.id_ready_o), 32'd0);
        step();
        #1 chk("stall_rs2_c3",   bus.ex_rs2_data_o,   32'h55);
        chk("stall_ready_c3",    32'(bus.id_ready_o), 32'd0);
        step();
        idle();
        step();
`else
        // RAW on the EX entry blocks ID until EX drains
        idle();
        bus.id_valid_i    = 1'b1;
        bus.id_rd_addr_i  = 5'd6;
        bus.id_regwrite_i = 1'b1;
        step();
        bus.id_pc_i       = 32'h300;
        bus.id_rs2_addr_i = 5'd6;
        bus.id_rd_addr_i  = 5'd8;
        bus.ex_ready_i    = 1'b0;
        #1 chk("haz_block_c1", 32'(bus.id_ready_o), 32'd0);
        step();
        #1 chk("haz_block_c2", 32'(bus.id_ready_o), 32'd0);
        bus.ex_ready_i = 1'b1;
        #1 chk("haz_block_drain", 32'(bus.id_ready_o), 32'd0);
        step();
        #1 chk("haz_release", 32'(bus.id_ready_o), 32'd1);
        step();
        chk("haz_accept_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("haz_accept_pc",    bus.ex_pc_o,         32'h300);
        idle();
        step();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            step();
        end

        rst_i = 1'b0;
        idle();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
